seq_divider: RTL and testbench

Multi-cycle unsigned restoring divider with a WIDTH parameter, one quotient bit resolved per clock. Generalises the 4-bit combinational divider: arbitrary width, a start/busy/done handshake, registered results and divide-by-zero detection. Used by datapath blocks that can tolerate WIDTH-cycle latency in exchange for a short critical path.

---
 rtl/div_pkg.sv | 5 +
 rtl/seq_divider_if.sv | 25 ++
 rtl/div_step.sv | 24 ++
 rtl/seq_divider.sv | 104 ++++++++++
 tb/tb_seq_divider.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;
    localparam int DIV_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] prem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] prem_o,
    output logic             qbit_o
);
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The restored remainder is always below the divisor, so the low WIDTH bits
    // of the modular difference are exact whenever the subtraction is taken.
    always_comb begin
        shifted = {prem_i, bit_i};
        diff    = shifted[WIDTH-1:0] - divisor_i;
        qbit_o  = (shifted >= {1'b0, divisor_i});
        prem_o  = qbit_o ? diff : shifted[WIDTH-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   state | meaning
//   IDLE  | waiting for start; results held
//   CALC  | iterating one quotient bit per cycle
//   DONE  | one-cycle done pulse, then back to IDLE
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] prem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;

    logic [WIDTH-1:0] prem_d;
    logic             qbit_d;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem_i    (prem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dsr_q),
        .prem_o    (prem_d),
        .qbit_o    (qbit_d)
    );

    // dvd_q shifts the dividend out of its top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            quo_q   <= '1;
                            rem_q   <= bus.dividend;
                            dbz_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            dvd_q   <= bus.dividend;
                            dsr_q   <= bus.divisor;
                            prem_q  <= '0;
                            cnt_q   <= '0;
                            dbz_q   <= 1'b0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    dvd_q  <= {dvd_q[WIDTH-2:0], qbit_d};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        quo_q   <= {dvd_q[WIDTH-2:0], qbit_d};
                        rem_q   <= prem_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and table-driven bench for seq_divider at WIDTH=8 and WIDTH=4.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_checks = 0;

    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(8)) if8 ();
    seq_divider_if #(.WIDTH(4)) if4 ();

    seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    seq_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        int         lat;
    } vec8_t;

    vec8_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left at a sample point (#1 after a rising edge) with the DUT idle.
    task automatic run8(input vec8_t v, input string tag);
        int lat;
        logic seen;
        if8.start = 1'b1; if8.dividend = v.a; if8.divisor = v.b;
        @(posedge clk); #1;
        if8.start = 1'b0;
        check({tag, " busy_after_accept"}, if8.busy, 1);
        lat = 0;
        seen = if8.done;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            seen = if8.done;
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, lat, v.lat);
        check({tag, " quotient"}, if8.quotient, v.q);
        check({tag, " remainder"}, if8.remainder, v.r);
        check({tag, " div_by_zero"}, if8.div_by_zero, v.dz);
        check({tag, " busy_in_done"}, if8.busy, 1);
        // a start during DONE must be ignored
        if8.start = 1'b1; if8.dividend = 8'd1; if8.divisor = 8'd1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        check({tag, " done_one_cycle"}, if8.done, 0);
        check({tag, " busy_after_done"}, if8.busy, 0);
        @(posedge clk); #1;
        check({tag, " start_in_done_ignored"}, if8.busy, 0);
        check({tag, " quotient_held"}, if8.quotient, v.q);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        output logic [3:0] q, output logic [3:0] r,
                        output logic dz, output int lat);
        logic seen;
        if4.start = 1'b1; if4.dividend = a; if4.divisor = b;
        @(posedge clk); #1;
        if4.start = 1'b0;
        lat = 0;
        seen = if4.done;
        while (!seen && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            seen = if4.done;
        end
        if (!seen) lat = -1;
        q = if4.quotient; r = if4.remainder; dz = if4.div_by_zero;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] ops_a[3];
        logic [7:0] ops_b[3];
        logic [7:0] ops_q[3];
        logic [7:0] ops_r[3];
        int idx, last, ndone;
        logic [3:0] q4, r4, a4, b4, eq4, er4;
        logic dz4;
        int lat4;

        tbl[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dz: 1'b0, lat: 8};
        tbl[1] = '{a: 8'd13,  b: 8'd0,   q: 8'hFF,  r: 8'd13, dz: 1'b1, lat: 0};
        tbl[2] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,  dz: 1'b0, lat: 8};
        tbl[3] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dz: 1'b0, lat: 8};
        tbl[4] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dz: 1'b0, lat: 8};
        tbl[5] = '{a: 8'd0,   b: 8'd4,   q: 8'd0,   r: 8'd0,  dz: 1'b0, lat: 8};
        tbl[6] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dz: 1'b0, lat: 8};
        tbl[7] = '{a: 8'd50,  b: 8'd6,   q: 8'd8,   r: 8'd2,  dz: 1'b0, lat: 8};

        ops_a = '{8'd100, 8'd90, 8'd250};
        ops_b = '{8'd10,  8'd7,  8'd16};
        ops_q = '{8'd10,  8'd12, 8'd15};
        ops_r = '{8'd0,   8'd6,  8'd10};

        if8.start = 1'b0; if8.dividend = '0; if8.divisor = '0;
        if4.start = 1'b0; if4.dividend = '0; if4.divisor = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", if8.busy, 0);
        check("reset done", if8.done, 0);
        check("reset quotient", if8.quotient, 0);
        check("reset remainder", if8.remainder, 0);
        check("reset div_by_zero", if8.div_by_zero, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run8(tbl[i], $sformatf("vec%0d %0d/%0d", i, tbl[i].a, tbl[i].b));
        end

        // start held high; operands scrambled while busy must not leak into results
        idx = 0; last = -1; ndone = 0;
        if8.start = 1'b1; if8.dividend = ops_a[0]; if8.divisor = ops_b[0];
        for (int cyc = 0; cyc < 60 && idx < 3; cyc++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                ndone++;
                check($sformatf("held op%0d quotient", idx), if8.quotient, ops_q[idx]);
                check($sformatf("held op%0d remainder", idx), if8.remainder, ops_r[idx]);
                check($sformatf("held op%0d div_by_zero", idx), if8.div_by_zero, 0);
                if (last >= 0) check($sformatf("held op%0d spacing", idx), cyc - last, 10);
                last = cyc;
                idx++;
                if (idx < 3) begin
                    if8.dividend = ops_a[idx]; if8.divisor = ops_b[idx];
                end else begin
                    if8.start = 1'b0;
                end
            end else if (if8.busy) begin
                if8.dividend = 8'hAA; if8.divisor = 8'd0;
            end
        end
        if8.start = 1'b0;
        check("held done count", ndone, 3);
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (if8.done) ndone++;
        end
        check("held no extra done", ndone, 0);

        // reset in the 4th CALC cycle discards the operation
        if8.start = 1'b1; if8.dividend = 8'd200; if8.divisor = 8'd7;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", if8.busy, 0);
        check("midrst done", if8.done, 0);
        check("midrst quotient", if8.quotient, 0);
        check("midrst remainder", if8.remainder, 0);
        check("midrst div_by_zero", if8.div_by_zero, 0);
        ndone = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(posedge clk); #1;
            if (if8.done) ndone++;
        end
        check("midrst no done", ndone, 0);
        run8(tbl[7], "after reset 50/6");

        // WIDTH=4 instance
        run4(4'd7, 4'd2, q4, r4, dz4, lat4);
        check("w4 7/2 latency", lat4, 4);
        check("w4 7/2 quotient", q4, 3);
        check("w4 7/2 remainder", r4, 1);
        check("w4 7/2 div_by_zero", dz4, 0);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'((i * 157 + 31) % 256);
            a4 = p[7:4];
            b4 = p[3:0];
            if (b4 == 4'd0) begin
                eq4 = 4'hF; er4 = a4;
            end else begin
                eq4 = a4 / b4; er4 = a4 % b4;
            end
            run4(a4, b4, q4, r4, dz4, lat4);
            check($sformatf("w4 %0d/%0d latency", a4, b4), lat4, (b4 == 4'd0) ? 0 : 4);
            check($sformatf("w4 %0d/%0d quotient", a4, b4), q4, eq4);
            check($sformatf("w4 %0d/%0d remainder", a4, b4), r4, er4);
            check($sformatf("w4 %0d/%0d div_by_zero", a4, b4), dz4, (b4 == 4'd0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
